imem_fetch_responder: RTL and testbench

//  Responder end of the instruction-fetch interface: serves 32-bit fetches from
//  a CPU front end over a valid/ready request and response handshake.

---
 rtl/imem_fetch_responder.sv | 99 +++++++++
 tb/tb_imem_fetch_responder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_responder.sv
// Instruction-fetch responder: serves 32-bit words from a loadable array after a fixed latency.
// Response held until accepted; one outstanding fetch at a time; the load port is never stalled.
module imem_fetch_responder #(
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [31:0]       req_addr_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_instr_o,
    output logic              rsp_err_o,
    input  logic              load_we_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic [31:0]       load_data_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [3:0]  CNT_INIT  = 4'(LATENCY - 1);

    logic [31:0]       mem_q [DEPTH];
    state_t            state_q;
    logic [3:0]        cnt_q;
    logic [31:0]       addr_q;
    logic              rsp_valid_q;
    logic [31:0]       rsp_instr_q;
    logic              rsp_err_q;

    logic [ADDR_W-1:0] idx_d;
    logic              err_d;
    logic [31:0]       instr_d;

    always_comb begin
        idx_d   = addr_q[ADDR_W+1:2];
        err_d   = (addr_q[1:0] != 2'b00) || (addr_q[31:ADDR_W+2] != '0);
        instr_d = err_d ? NOP_INSTR : mem_q[idx_d];
    end

    // cnt_q holds the WAIT edges still to pass before the entering edge, so
    // RESP is entered exactly LATENCY edges after the accept edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_instr_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        addr_q  <= req_addr_i;
                        cnt_q   <= CNT_INIT;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_instr_q <= instr_d;
                        rsp_err_q   <= err_d;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Read in the FSM block samples the old word, so a same-edge load is not seen.
    always_ff @(posedge clk_i) begin
        if (load_we_i) begin
            mem_q[load_addr_i] <= load_data_i;
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_instr_o = rsp_instr_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Bench: three responders (LATENCY 2, 1, 4) sharing clock, reset and load port,
// checked by table vectors, directed corner sequences and a random run against a word-array model.
module tb_imem_fetch_responder;

    localparam int DEPTH = 256;
    localparam int ND    = 3;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid [ND];
    logic        req_ready [ND];
    logic [31:0] req_addr  [ND];
    logic        rsp_valid [ND];
    logic        rsp_ready [ND];
    logic [31:0] rsp_instr [ND];
    logic        rsp_err   [ND];
    logic        busy      [ND];
    logic        load_we;
    logic [7:0]  load_addr;
    logic [31:0] load_data;

    logic [31:0] model_mem [DEPTH];
    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    imem_fetch_responder #(.DEPTH(256), .ADDR_W(8), .LATENCY(2)) u_l2 (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_addr_i(req_addr[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]), .rsp_instr_o(rsp_instr[0]),
        .rsp_err_o(rsp_err[0]), .load_we_i(load_we), .load_addr_i(load_addr),
        .load_data_i(load_data), .busy_o(busy[0]));

    imem_fetch_responder #(.DEPTH(256), .ADDR_W(8), .LATENCY(1)) u_l1 (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_addr_i(req_addr[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]), .rsp_instr_o(rsp_instr[1]),
        .rsp_err_o(rsp_err[1]), .load_we_i(load_we), .load_addr_i(load_addr),
        .load_data_i(load_data), .busy_o(busy[1]));

    imem_fetch_responder #(.DEPTH(256), .ADDR_W(8), .LATENCY(4)) u_l4 (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid[2]), .req_ready_o(req_ready[2]), .req_addr_i(req_addr[2]),
        .rsp_valid_o(rsp_valid[2]), .rsp_ready_i(rsp_ready[2]), .rsp_instr_o(rsp_instr[2]),
        .rsp_err_o(rsp_err[2]), .load_we_i(load_we), .load_addr_i(load_addr),
        .load_data_i(load_data), .busy_o(busy[2]));

    function automatic int lat_of(input int d);
        case (d)
            0:       return 2;
            1:       return 1;
            default: return 4;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Fetch outcome from the address rules: misaligned or beyond the array gives NOP + err.
    function automatic void model_exp(input logic [31:0] a, output logic [31:0] ins, output logic e);
        e   = (a % 4 != 0) || (a >= 32'(DEPTH * 4));
        ins = e ? 32'h0000_0013 : model_mem[8'(a >> 2)];
    endfunction

    task automatic drive_load(input logic [7:0] a, input logic [31:0] v);
        load_we   = 1'b1;
        load_addr = a;
        load_data = v;
    endtask

    task automatic commit_load();
        if (load_we) model_mem[load_addr] = load_data;
    endtask

    task automatic load(input logic [7:0] a, input logic [31:0] v);
        drive_load(a, v);
        @(posedge clk_i);
        commit_load();
        @(negedge clk_i);
        load_we = 1'b0;
    endtask

    // Called at a negedge with instance d idle. Returns the held response and the model's expectation.
    task automatic fetch(input int d, input logic [31:0] addr, input int stall, input bit rnd_load,
                         input bit coll, input logic [7:0] caddr, input logic [31:0] cdata,
                         output logic [31:0] got_i, output logic got_e,
                         output logic [31:0] exp_i, output logic exp_e);
        int L;
        int lat_seen;
        int low_cnt;
        int unstable;
        L = lat_of(d);
        exp_i = 32'd0;
        exp_e = 1'b0;
        unstable = 0;
        chk("idle_req_ready", 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1;
        req_addr[d]  = addr;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid[d] = 1'b0;
        req_addr[d]  = $urandom;
        low_cnt  = (req_ready[d] == 1'b0) ? 1 : 0;
        lat_seen = rsp_valid[d] ? 0 : -1;
        for (int e = 1; e <= L; e++) begin
            rsp_ready[d] = 1'($urandom_range(1));
            if (e == L) begin
                model_exp(addr, exp_i, exp_e);
                if (coll) drive_load(caddr, cdata);
            end else if (rnd_load && $urandom_range(1) == 1) begin
                drive_load(8'($urandom), $urandom);
            end
            @(posedge clk_i);
            commit_load();
            @(negedge clk_i);
            load_we = 1'b0;
            if (req_ready[d] == 1'b0) low_cnt++;
            if (rsp_valid[d] && lat_seen < 0) lat_seen = e;
        end
        chk("rsp_latency", 32'(lat_seen), 32'(L));
        got_i = rsp_instr[d];
        got_e = rsp_err[d];
        for (int s = 0; s < stall; s++) begin
            rsp_ready[d] = 1'b0;
            req_valid[d] = 1'b1;
            req_addr[d]  = $urandom;
            if (rnd_load) drive_load(8'($urandom), $urandom);
            @(posedge clk_i);
            commit_load();
            @(negedge clk_i);
            load_we = 1'b0;
            if (req_ready[d] == 1'b0) low_cnt++;
            if (!rsp_valid[d] || rsp_instr[d] !== got_i || rsp_err[d] !== got_e) unstable++;
        end
        if (stall > 0) chk("rsp_hold_stable", 32'(unstable), 32'd0);
        req_valid[d] = 1'b0;
        rsp_ready[d] = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        rsp_ready[d] = 1'b0;
        chk("rsp_valid_drop", 32'(rsp_valid[d]), 32'd0);
        chk("busy_after_hs", 32'(busy[d]), 32'd0);
        chk("req_ready_low_cycles", 32'(low_cnt), 32'(L + 1 + stall));
    endtask

    typedef struct {
        logic [31:0] addr;
        int          stall;
        logic [31:0] instr;
        logic        err;
    } vec_t;

    initial begin
        vec_t        vecs [7];
        logic [31:0] gi, ei;
        logic        ge, ee;
        int          seen;

        vecs[0] = '{32'h0,   0, 32'h0050_0093, 1'b0};
        vecs[1] = '{32'h4,   0, 32'h00A0_0113, 1'b0};
        vecs[2] = '{32'h8,   0, 32'h0020_81B3, 1'b0};
        vecs[3] = '{32'hC,   0, 32'h4020_8233, 1'b0};
        vecs[4] = '{32'h4,   5, 32'h00A0_0113, 1'b0};
        vecs[5] = '{32'h6,   0, 32'h0000_0013, 1'b1};
        vecs[6] = '{32'h400, 1, 32'h0000_0013, 1'b1};

        rst_i = 1'b1;
        load_we = 1'b0;
        load_addr = 8'd0;
        load_data = 32'd0;
        for (int d = 0; d < ND; d++) begin
            req_valid[d] = 1'b0;
            req_addr[d]  = 32'd0;
            rsp_ready[d] = 1'b0;
        end
        @(negedge clk_i);
        @(negedge clk_i);
        for (int d = 0; d < ND; d++) begin
            chk("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
            chk("rst_rsp_instr", rsp_instr[d], 32'd0);
            chk("rst_rsp_err", 32'(rsp_err[d]), 32'd0);
            chk("rst_busy", 32'(busy[d]), 32'd0);
            chk("rst_req_ready", 32'(req_ready[d]), 32'd1);
        end
        rst_i = 1'b0;
        @(negedge clk_i);

        for (int i = 0; i < DEPTH; i++) load(8'(i), $urandom);
        load(8'd0, 32'h0050_0093);
        load(8'd1, 32'h00A0_0113);
        load(8'd2, 32'h0020_81B3);
        load(8'd3, 32'h4020_8233);

        // Program fetches, held response, error fetches on every latency.
        for (int d = 0; d < ND; d++) begin
            for (int v = 0; v < 7; v++) begin
                fetch(d, vecs[v].addr, vecs[v].stall, 1'b0, 1'b0, 8'd0, 32'd0, gi, ge, ei, ee);
                chk("vec_instr", gi, vecs[v].instr);
                chk("vec_err", 32'(ge), 32'(vecs[v].err));
            end
        end

        // Load on the edge that enters RESP is not seen; the next fetch sees it.
        fetch(0, 32'h8, 0, 1'b0, 1'b1, 8'd2, 32'hDEAD_BEEF, gi, ge, ei, ee);
        chk("coll_old_word", gi, 32'h0020_81B3);
        fetch(0, 32'h8, 2, 1'b0, 1'b0, 8'd0, 32'd0, gi, ge, ei, ee);
        chk("coll_new_word", gi, 32'hDEAD_BEEF);

        // Reset one cycle into WAIT aborts the fetch.
        req_valid[0] = 1'b1;
        req_addr[0]  = 32'h0;
        rsp_ready[0] = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid[0] = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        chk("wait_busy", 32'(busy[0]), 32'd1);
        rst_i = 1'b1;
        #1;
        chk("abort_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("abort_req_ready", 32'(req_ready[0]), 32'd1);
        chk("abort_busy", 32'(busy[0]), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            if (rsp_valid[0]) seen++;
        end
        rsp_ready[0] = 1'b0;
        chk("abort_no_rsp", 32'(seen), 32'd0);
        fetch(0, 32'h0, 0, 1'b0, 1'b0, 8'd0, 32'd0, gi, ge, ei, ee);
        chk("mem_kept_after_rst", gi, 32'h0050_0093);

        // Random fetches with loads in flight, stalls and collisions.
        for (int n = 0; n < 90; n++) begin
            int          d;
            logic [31:0] a;
            d = int'($urandom_range(ND - 1));
            case ($urandom_range(9))
                7:       a = 32'($urandom_range(1023));
                8:       a = $urandom;
                9:       a = 32'h400 + 32'($urandom_range(255) * 4);
                default: a = 32'($urandom_range(255)) << 2;
            endcase
            fetch(d, a, int'($urandom_range(3)), 1'b1, 1'($urandom_range(1)),
                  8'($urandom), $urandom, gi, ge, ei, ee);
            chk("rnd_instr", gi, ei);
            chk("rnd_err", 32'(ge), 32'(ee));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
